// File: rtl/pulse_peak_detector.sv
// Pulse-height analyser: threshold-triggered peak/time/width capture into a first-word-fall-through event FIFO.
// Optional pile-up rejection of over-wide pulses: define PULSE_PEAK_PILEUP_REJECT_EN.
module pulse_peak_detector #(
  parameter int DATA_W      = 16,
  parameter int TS_W        = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLDOFF_CYC = 8,
  parameter int MAX_WIDTH   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] threshold,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]   peak_time,
  output logic [7:0]        peak_width,
  output logic [15:0]       drop_count,
  output logic [15:0]       pileup_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
  localparam logic [8:0]    MAX_W     = 9'(MAX_WIDTH);
  localparam int EW = DATA_W + TS_W + 8;

  typedef enum logic [1:0] {IDLE, TRACK, HOLDOFF} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sample_r;
  logic [TS_W-1:0]   ts, ts_r;
  logic [DATA_W-1:0] max_r;
  logic [TS_W-1:0]   max_t;
  logic [7:0]        width;
  logic [HW-1:0]     hold_cnt;
  logic              above, gt_max;
  logic              start, extend, pulse_end;
  logic              reject, push_req, push, pop, drop, full, empty;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [EW-1:0]     mem [FIFO_DEPTH];

  assign above  = $signed(sample_r) > $signed(threshold);
  assign gt_max = $signed(sample_r) > $signed(max_r);

  // Input stage: every sample travels with its own timestamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_r <= '0;
      ts_r     <= '0;
      ts       <= '0;
    end else begin
      sample_r <= input_data;
      ts_r     <= ts;
      ts       <= ts + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    extend    = 1'b0;
    pulse_end = 1'b0;
    case (state)
      IDLE:
        if (above) begin
          state_nxt = TRACK;
          start     = 1'b1;
        end
      TRACK:
        if (above) begin
          extend = 1'b1;
        end else begin
          pulse_end = 1'b1;
          state_nxt = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
        end
      HOLDOFF:
        if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ties keep the earliest timestamp because only a strictly larger sample updates the peak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_r    <= '0;
      max_t    <= '0;
      width    <= '0;
      hold_cnt <= '0;
    end else begin
      if (start) begin
        max_r <= sample_r;
        max_t <= ts_r;
        width <= 8'd1;
      end else if (extend) begin
        if (width != 8'hFF) width <= width + 8'd1;
        if (gt_max) begin
          max_r <= sample_r;
          max_t <= ts_r;
        end
      end
      if (pulse_end)                                  hold_cnt <= HOLD_LOAD;
      else if (state == HOLDOFF && hold_cnt != '0)    hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef PULSE_PEAK_PILEUP_REJECT_EN
  assign reject = pulse_end && ({1'b0, width} > MAX_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 pileup_count <= '0;
    else if (reject && pileup_count != 16'hFFFF) pileup_count <= pileup_count + 16'd1;
  end
`else
  logic unused_max_width;
  assign unused_max_width = ({1'b0, width} > MAX_W);
  assign reject           = 1'b0;
  assign pileup_count     = '0;
`endif

  assign push_req = pulse_end & ~reject;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = peak_valid & peak_ready;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {max_r, max_t, width};
  end

  assign peak_valid = ~empty;
  assign {peak_amp, peak_time, peak_width} = peak_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector: single pulse, tie, backpressure, holdoff, pile-up, async reset.
module tb_pulse_peak_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] input_data = '0;
  logic [15:0] threshold = 16'd200;
  logic        peak_valid;
  logic        peak_ready = 1'b0;
  logic [15:0] peak_amp;
  logic [31:0] peak_time;
  logic [7:0]  peak_width;
  logic [15:0] drop_count;
  logic [15:0] pileup_count;

  int vectors = 0;
  int miscompares = 0;
  int tsc = 0;
  int t_exp;

  pulse_peak_detector dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .threshold    (threshold),
    .peak_valid   (peak_valid),
    .peak_ready   (peak_ready),
    .peak_amp     (peak_amp),
    .peak_time    (peak_time),
    .peak_width   (peak_width),
    .drop_count   (drop_count),
    .pileup_count (pileup_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] v);
    input_data = v;
    @(posedge clk);
    #1;
    tsc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'd0);
  endtask

  task automatic pop_one();
    peak_ready = 1'b1;
    step(16'd0);
    peak_ready = 1'b0;
  endtask

  initial begin
    #23;
    check("reset_valid", peak_valid, 0);
    check("reset_amp", peak_amp, 0);
    check("reset_drop", drop_count, 0);
    reset = 1'b0;
    tsc = 0;

    // single pulse
    step(0); step(100); step(300); step(500); step(300); step(100);
    check("single_valid_early", peak_valid, 0);
    step(0);
    check("single_valid", peak_valid, 1);
    check("single_amp", peak_amp, 500);
    check("single_time", peak_time, 3);
    check("single_width", peak_width, 3);
    pop_one();
    check("single_popped", peak_valid, 0);
    idle(10);

    // plateau tie keeps earliest time
    step(0);
    t_exp = tsc;
    step(400); step(400); step(0); step(0);
    check("tie_amp", peak_amp, 400);
    check("tie_time", peak_time, t_exp);
    check("tie_width", peak_width, 2);
    pop_one();
    idle(10);

    // backpressure: five events into a four-deep FIFO
    for (int a = 3; a <= 7; a++) begin
      step(16'(a * 100));
      step(0);
      idle(12);
    end
    check("bp_valid", peak_valid, 1);
    check("bp_drop", drop_count, 1);
    check("bp_stable", peak_amp, 300);
    peak_ready = 1'b1;
    for (int a = 3; a <= 6; a++) begin
      check("bp_order", peak_amp, 64'(a * 100));
      step(0);
    end
    peak_ready = 1'b0;
    check("bp_empty", peak_valid, 0);

    // holdoff: second pulse is inside dead time, third is after it
    step(300); step(0); step(0);
    step(0); step(0); step(350); step(350); step(0);
    step(0); step(0); step(0); step(0);
    step(450); step(0); step(0);
    check("ho_first", peak_amp, 300);
    pop_one();
    check("ho_second", peak_amp, 450);
    pop_one();
    check("ho_empty", peak_valid, 0);
    idle(10);

    // pile-up: 70 samples above threshold
    step(0);
    t_exp = tsc;
    for (int i = 0; i < 70; i++) step(300);
    step(0); step(0);
`ifdef PULSE_PEAK_PILEUP_REJECT_EN
    check("pu_valid", peak_valid, 0);
    check("pu_count", pileup_count, 1);
`else
    check("pu_valid", peak_valid, 1);
    check("pu_width", peak_width, 70);
    check("pu_time", peak_time, t_exp);
    check("pu_count", pileup_count, 0);
`endif
    idle(10);

    // async reset mid-pulse with an event still queued and drop_count nonzero
    step(250); step(0); idle(10);
    check("rst_pre_valid", peak_valid, 1);
    step(600); step(600); step(600);
    reset = 1'b1;
    #1;
    check("rst_valid", peak_valid, 0);
    check("rst_amp", peak_amp, 0);
    check("rst_drop", drop_count, 0);
    check("rst_pileup", pileup_count, 0);
    #1;
    reset = 1'b0;
    tsc = 0;
    step(0); step(0); step(0);
    check("rst_no_event", peak_valid, 0);
    step(0); step(0);
    step(650); step(0); step(0);
    check("rst_new_valid", peak_valid, 1);
    check("rst_new_amp", peak_amp, 650);
    check("rst_ts_restart", peak_time, 5);
    check("rst_new_width", peak_width, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_peak_detector.md
# pulse_peak_detector

Pulse-height analysis stage placed directly downstream of the trapezoidal shaping filter. It consumes the filter's signed 16-bit shaped stream, detects pulses that cross a programmable threshold, and captures each pulse's peak amplitude, timestamp and width. Captured events are buffered in a small FIFO and presented on a valid/ready interface to the readout logic.

## Interface
- DATA_W, 16: width of shaped input samples and of peak amplitude (signed).
- TS_W, 32: timestamp counter width.
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- HOLDOFF_CYC, 8: dead-time cycles after each pulse end (0 allowed).
- MAX_WIDTH, 64: pile-up width limit in samples; used only with the macro in Configuration.

- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- input_data  in  DATA_W  signed shaped sample from the filter, one per clk.
- threshold  in  DATA_W  signed trigger level; quasi-static, sampled every cycle.
- peak_valid  out  1  FIFO head holds an event; reset 0.
- peak_ready  in  1  consumer accepts the head on a clk edge where peak_valid=1.
- peak_amp  out  DATA_W  signed peak amplitude of head event; reset 0.
- peak_time  out  TS_W  timestamp of peak sample; reset 0.
- peak_width  out  8  above-threshold sample count, saturating at 255; reset 0.
- drop_count  out  16  events lost to FIFO full, saturating; reset 0.
- pileup_count  out  16  events rejected as pile-up, saturating; reset 0.

## Operation
- Input stage: input_data is registered into sample_r. A free-running TS_W counter ts is captured alongside it into ts_r. The first sample after reset release has ts_r=0. ts wraps modulo 2^TS_W.
- All comparisons are signed and use sample_r.
- FSM states: IDLE, TRACK, HOLDOFF.
- IDLE → TRACK when sample_r > threshold (strict). On that transition: max=sample_r, max_t=ts_r, width=1.
- TRACK with sample_r > threshold:
  - width increments, saturating at 255.
  - If sample_r > max (strict), update max and max_t. On a tie, the earliest sample's time is kept.
- TRACK with sample_r <= threshold: the pulse ends. Push {max, max_t, width} into the FIFO, then go to HOLDOFF. If HOLDOFF_CYC=0, go directly to IDLE.
- HOLDOFF: counts HOLDOFF_CYC cycles and ignores input, then goes to IDLE. A pulse still above threshold on return to IDLE starts a new event.
- FIFO behaviour:
  - First-word fall-through: the head is presented on the peak_* outputs while peak_valid=1.
  - A pop occurs on a clk edge with peak_valid & peak_ready.
  - Push onto a full FIFO with no pop in the same cycle: the event is discarded and drop_count increments.
  - Push and pop in the same cycle while full: both succeed, no drop.
  - Push onto an empty FIFO: the entry becomes the head.
- Outputs stay stable while peak_valid=1 and peak_ready=0.
- Reset mid-pulse: the FSM goes to IDLE, the FIFO empties, counters clear, ts restarts at 0, and the in-flight event is lost.

## Timing
- The sub-threshold sample presented on input_data before edge N is captured at edge N. The event is written at edge N+1. peak_valid=1 after edge N+1. If the FIFO was not empty, the event queues behind earlier entries.
- Throughput: one input sample per cycle. Minimum event spacing is 2 + HOLDOFF_CYC cycles.
- Pop-to-next-head: zero bubble. The next entry is visible immediately after the popping edge.
- drop_count and pileup_count update on the same edge as the corresponding push attempt.

## Configuration
- PULSE_PEAK_PILEUP_REJECT_EN defined:
  - At pulse end, if width > MAX_WIDTH, the event is not pushed and pileup_count increments (saturating).
  - HOLDOFF still applies after a rejected event.
  - A pile-up rejection never increments drop_count.
- Not defined: every event is pushed regardless of width, and pileup_count is tied to 0.

## Test plan
- Single pulse: threshold=200, inputs 0,100,300,500,300,100,0 at ts 0..6 → one event with peak_amp=500, peak_time=3, peak_width=3; peak_valid asserted 2 edges after the sample 100 at ts 5 is presented.
- Plateau tie: threshold=200, inputs 0,400,400,0 → peak_amp=400, peak_time=1, peak_width=2.
- Backpressure: peak_ready=0, five separated pulses with amplitudes 300..700, FIFO_DEPTH=4 → four entries held, drop_count=1; then assert peak_ready → amplitudes 300,400,500,600 popped in order, peak_valid falls.
- Holdoff: HOLDOFF_CYC=8; second pulse crosses 3 cycles after the first ends and falls before holdoff expires → exactly one event; a pulse arriving 10 cycles after the first ends → second event.
- Pile-up: pulse above threshold for 70 samples, MAX_WIDTH=64 → with macro, no event and pileup_count=1; without macro, one event with peak_width=70.
- Async reset: assert reset mid-TRACK between edges → all outputs go to 0 immediately; after release, no event from the interrupted pulse and ts restarts at 0.
